run_sequencer: RTL and testbench
================================

Name: run_sequencer

Overview:
- Top-level run controller for the Hack-style computer: sequences program load, CPU execution and RAM dump for one simulation/FPGA run.
- Owns the ROM/RAM write and read ports outside RUN, holds the CPU in reset outside RUN, and detects end of program or timeout.
- Replaces file-based init/dump with stream interfaces, so a host or testbench can drive runs back-to-back.

Parameters:
ROM_SIZE, 1024, program ROM depth in words; end of program when pc >= ROM_SIZE.
RAM_SIZE, 1024, data RAM depth in words; dump range 0..RAM_SIZE-1.
RESET_CYCLES, 2, cycles cpu_reset is held high after load before RUN (min 1).
MAX_CYCLES, 65536, RUN-cycle limit before forced stop.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; low forces IDLE immediately
start  in  1  begin a run (sampled in IDLE/DONE)
load_valid  in  1  load word valid
load_ready  out  1  sequencer accepts load word
load_sel  in  1  0 = ROM, 1 = RAM
load_addr  in  16  target word address
load_data  in  16  word to write
load_last  in  1  final load word
cpu_reset  out  1  active-high reset to CPU
cpu_pc  in  16  CPU program counter
mem_own  out  1  1 = sequencer drives memory ports, 0 = CPU drives them
rom_we  out  1  ROM write strobe
ram_we  out  1  RAM write strobe
mem_addr  out  16  ROM/RAM address when mem_own=1
mem_wdata  out  16  write data
ram_rdata  in  16  RAM read data, combinational on mem_addr
dump_valid  out  1  dump word valid
dump_ready  in  1  consumer accepts dump word
dump_addr  out  16  address of dump word
dump_data  out  16  dump word (= ram_rdata)
dump_last  out  1  dump word is RAM_SIZE-1
busy  out  1  state not IDLE/DONE
done  out  1  run finished (DONE state)
timeout  out  1  run stopped by MAX_CYCLES
cycle_count  out  32  RUN cycles of current/last run

Behaviour:
- States: IDLE, LOAD, HOLD, RUN, DUMP, DONE. Registered state; outputs are decoded from state and registers. Handshake strobes are combinational.
- Reset (low, any time, including mid-run): state=IDLE, cpu_reset=1, mem_own=1, load_ready=0, rom_we=ram_we=0, dump_valid=0, done=0, timeout=0, busy=0, cycle_count=0, hold/dump counters=0.
- IDLE/DONE: start=1 -> LOAD next edge. Entering LOAD clears cycle_count, timeout and done.
- LOAD: load_ready=1, cpu_reset=1, mem_own=1, mem_addr=load_addr, mem_wdata=load_data.
  - Write fires on a load handshake (load_valid & load_ready) in the same cycle: rom_we = handshake & ~load_sel, ram_we = handshake & load_sel.
  - Out-of-range address (>= ROM_SIZE or >= RAM_SIZE for the selected memory): word is accepted, write is suppressed.
  - Handshake with load_last=1 -> HOLD.
  - load_valid low: stay in LOAD indefinitely.
- HOLD: cpu_reset=1, mem_own=0, no writes. Stays RESET_CYCLES cycles, then -> RUN.
- RUN: cpu_reset=0, mem_own=0, rom_we=ram_we=0. cycle_count increments every RUN cycle, saturating at 2^32-1.
  - cpu_pc >= ROM_SIZE -> DUMP, timeout=0.
  - Else if cycle_count == MAX_CYCLES-1 on this edge -> DUMP, timeout=1.
  - If both conditions hold on the same edge, pc end wins (timeout=0).
- DUMP: cpu_reset=1, mem_own=1, mem_addr=dump_addr, dump_valid=1, dump_data=ram_rdata, dump_last = (dump_addr == RAM_SIZE-1).
  - dump_addr starts at 0 and advances by 1 per handshake only.
  - dump_data/addr hold stable while dump_ready=0.
  - Handshake with dump_last -> DONE; dump_addr returns to 0.
- DONE: done=1, cpu_reset=1, mem_own=1. cycle_count and timeout hold until the next start.
- start outside IDLE/DONE: ignored.

Test Plan:
1. Reset low mid-RUN at cycle 10 -> state IDLE the same cycle; cpu_reset=1, cycle_count=0, done=0, no writes.
2. Load ROM[0..2] plus RAM[0]=5 (last on RAM word), cpu_pc forced 0,1,2,3 with ROM_SIZE=3:
   - rom_we pulses 3x, ram_we pulses 1x, on the handshake cycles only.
   - HOLD lasts 2 cycles; RUN lasts 4 cycles, cycle_count=4.
   - DUMP follows; timeout=0.
3. Load word with load_sel=1, load_addr=RAM_SIZE -> load_ready=1 accepts the word; ram_we=0.
4. cpu_pc stuck at 0, MAX_CYCLES=16 -> DUMP entered after 16 RUN cycles; timeout=1, cycle_count=16.
5. DUMP with RAM_SIZE=4, RAM={7,8,9,10}, dump_ready toggling 1,0,1,0...:
   - 4 words in order 7,8,9,10, stable during stalls.
   - dump_last only on address 3; DONE after the 4th handshake.
6. From DONE, start=1 with load_last on the first word -> second run completes; cycle_count and timeout are cleared at LOAD entry.

Source files
------------

// File: rtl/run_sequencer_if.sv
// ---------------------------------------------------------------------------
// run_sequencer_if
// Bundles every non-clock signal of the run sequencer: run control (start),
// the program/data load stream, the CPU control pair (cpu_reset, cpu_pc), the
// ROM/RAM access port, the RAM dump stream and the status outputs.
//
// Modports:
//   master - the sequencer itself (drives load_ready, memory port, dump
//            stream and status; samples start, load stream, cpu_pc,
//            ram_rdata and dump_ready)
//   slave  - the surrounding system / host / testbench (the opposite side)
// ---------------------------------------------------------------------------
interface run_sequencer_if;

  // Run control
  logic        start;

  // Load stream (host -> sequencer)
  logic        load_valid;
  logic        load_ready;
  logic        load_sel;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  logic        load_last;

  // CPU control
  logic        cpu_reset;
  logic [15:0] cpu_pc;

  // Shared ROM/RAM port
  logic        mem_own;
  logic        rom_we;
  logic        ram_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] ram_rdata;

  // Dump stream (sequencer -> host)
  logic        dump_valid;
  logic        dump_ready;
  logic [15:0] dump_addr;
  logic [15:0] dump_data;
  logic        dump_last;

  // Status
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] cycle_count;

  modport master (
    input  start, load_valid, load_sel, load_addr, load_data, load_last,
           cpu_pc, ram_rdata, dump_ready,
    output load_ready, cpu_reset, mem_own, rom_we, ram_we, mem_addr,
           mem_wdata, dump_valid, dump_addr, dump_data, dump_last,
           busy, done, timeout, cycle_count
  );

  modport slave (
    output start, load_valid, load_sel, load_addr, load_data, load_last,
           cpu_pc, ram_rdata, dump_ready,
    input  load_ready, cpu_reset, mem_own, rom_we, ram_we, mem_addr,
           mem_wdata, dump_valid, dump_addr, dump_data, dump_last,
           busy, done, timeout, cycle_count
  );

endinterface

// File: rtl/run_sequencer.sv
// ---------------------------------------------------------------------------
// run_sequencer
// Run controller for the Hack-style computer. One run is:
//   LOAD (stream program/data words into ROM/RAM) -> HOLD (CPU kept in reset
//   for RESET_CYCLES) -> RUN (CPU free-running until pc leaves the ROM or the
//   cycle limit is hit) -> DUMP (stream all of RAM out) -> DONE.
// Outside RUN the sequencer owns the memory port and holds the CPU in reset.
//
// Ports:
//   i_clk   - clock, all state on the rising edge
//   i_rst_n - asynchronous active-low reset, forces IDLE immediately
//   bus     - run_sequencer_if.master (load/dump streams, memory port,
//             CPU control and status)
// ---------------------------------------------------------------------------
module run_sequencer #(
  parameter int unsigned ROM_SIZE     = 1024,
  parameter int unsigned RAM_SIZE     = 1024,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 65536
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  run_sequencer_if.master  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DUMP = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // 17-bit limits so a depth of 65536 still compares correctly against
  // 16-bit addresses.
  localparam logic [16:0] ROM_LIM   = 17'(ROM_SIZE);
  localparam logic [16:0] RAM_LIM   = 17'(RAM_SIZE);
  localparam logic [15:0] DUMP_LAST = 16'(RAM_SIZE - 1);
  localparam logic [15:0] HOLD_LAST = 16'(RESET_CYCLES - 1);
  localparam logic [31:0] RUN_LAST  = 32'(MAX_CYCLES - 1);

  logic [2:0]  r_state;
  logic [15:0] r_holdCnt;
  logic [15:0] r_dumpAddr;
  logic [31:0] r_cycleCount;
  logic        r_timeout;

  logic w_loadFire;
  logic w_romInRange;
  logic w_ramInRange;
  logic w_dumpFire;
  logic w_dumpLast;
  logic w_pcEnd;
  logic w_runLimit;

  assign w_loadFire   = (r_state == S_LOAD) & bus.load_valid;
  assign w_romInRange = {1'b0, bus.load_addr} < ROM_LIM;
  assign w_ramInRange = {1'b0, bus.load_addr} < RAM_LIM;
  assign w_dumpFire   = (r_state == S_DUMP) & bus.dump_ready;
  assign w_dumpLast   = (r_dumpAddr == DUMP_LAST);
  assign w_pcEnd      = {1'b0, bus.cpu_pc} >= ROM_LIM;
  assign w_runLimit   = (r_cycleCount == RUN_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_holdCnt    <= '0;
      r_dumpAddr   <= '0;
      r_cycleCount <= '0;
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // Run statistics of the previous run survive until the next start.
          if (bus.start) begin
            r_state      <= S_LOAD;
            r_cycleCount <= '0;
            r_timeout    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_loadFire && bus.load_last) begin
            r_state   <= S_HOLD;
            r_holdCnt <= '0;
          end
        end
        S_HOLD: begin
          if (r_holdCnt == HOLD_LAST) begin
            r_state   <= S_RUN;
            r_holdCnt <= '0;
          end else begin
            r_holdCnt <= r_holdCnt + 16'd1;
          end
        end
        S_RUN: begin
          if (r_cycleCount != '1) begin
            r_cycleCount <= r_cycleCount + 32'd1;
          end
          // A program that ends on the same edge as the limit is a clean end.
          if (w_pcEnd) begin
            r_state    <= S_DUMP;
            r_timeout  <= 1'b0;
            r_dumpAddr <= '0;
          end else if (w_runLimit) begin
            r_state    <= S_DUMP;
            r_timeout  <= 1'b1;
            r_dumpAddr <= '0;
          end
        end
        S_DUMP: begin
          if (w_dumpFire) begin
            if (w_dumpLast) begin
              r_state    <= S_DONE;
              r_dumpAddr <= '0;
            end else begin
              r_dumpAddr <= r_dumpAddr + 16'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory port mux: load stream in LOAD, dump pointer in DUMP.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (r_state == S_LOAD) begin
      bus.mem_addr  = bus.load_addr;
      bus.mem_wdata = bus.load_data;
    end else if (r_state == S_DUMP) begin
      bus.mem_addr = r_dumpAddr;
    end
  end

  // Out-of-range load words are still accepted; only the strobe is dropped.
  assign bus.rom_we      = w_loadFire & ~bus.load_sel & w_romInRange;
  assign bus.ram_we      = w_loadFire &  bus.load_sel & w_ramInRange;

  assign bus.load_ready  = (r_state == S_LOAD);
  assign bus.cpu_reset   = (r_state != S_RUN);
  assign bus.mem_own     = (r_state != S_HOLD) && (r_state != S_RUN);

  assign bus.dump_valid  = (r_state == S_DUMP);
  assign bus.dump_addr   = r_dumpAddr;
  assign bus.dump_data   = bus.ram_rdata;
  assign bus.dump_last   = (r_state == S_DUMP) & w_dumpLast;

  assign bus.busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.timeout     = r_timeout;
  assign bus.cycle_count = r_cycleCount;

endmodule

// File: tb/tb_run_sequencer.sv
// ---------------------------------------------------------------------------
// tb_run_sequencer
// Self-checking bench for run_sequencer with small ROM/RAM depths. Provides a
// behavioural RAM, a toy CPU whose pc leaves the ROM after a chosen number of
// RUN cycles, and a run-level reference model.
// ---------------------------------------------------------------------------
module tb_run_sequencer;

  localparam int ROM_SIZE     = 8;
  localparam int RAM_SIZE     = 4;
  localparam int RESET_CYCLES = 2;
  localparam int MAX_CYCLES   = 16;

  typedef struct {
    logic        sel;
    logic [15:0] addr;
    logic [15:0] data;
  } loadWord_t;

  typedef struct {
    int nWords;
    int pcEnd;
    int expCycles;
    bit expTimeout;
    int stall;
  } runVec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  loadWord_t   loadQ[$];
  logic [15:0] ramMem [RAM_SIZE] = '{default: 16'h0};
  logic [15:0] expRam [RAM_SIZE] = '{default: 16'h0};
  int romWrites = 0;
  int ramWrites = 0;
  int runCyc = 0;
  int pcEnd = -1;

  always #5 clk = ~clk;

  run_sequencer_if bus();

  run_sequencer #(
    .ROM_SIZE    (ROM_SIZE),
    .RAM_SIZE    (RAM_SIZE),
    .RESET_CYCLES(RESET_CYCLES),
    .MAX_CYCLES  (MAX_CYCLES)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // Behavioural memories and a toy CPU that counts its own RUN cycles.
  always @(posedge clk) begin
    if (bus.rom_we) romWrites <= romWrites + 1;
    if (bus.ram_we) begin
      ramMem[bus.mem_addr[1:0]] <= bus.mem_wdata;
      ramWrites <= ramWrites + 1;
    end
    runCyc <= bus.cpu_reset ? 0 : runCyc + 1;
  end

  always_comb begin
    bus.ram_rdata = (bus.mem_addr < 16'(RAM_SIZE)) ? ramMem[bus.mem_addr[1:0]] : 16'hDEAD;
  end

  // pc walks inside the ROM until RUN cycle pcEnd, then sits exactly at
  // ROM_SIZE (the boundary). A negative pcEnd means the program never ends.
  always_comb begin
    if (pcEnd >= 0 && runCyc >= pcEnd) bus.cpu_pc = 16'(ROM_SIZE);
    else                                bus.cpu_pc = 16'(runCyc % ROM_SIZE);
  end

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nextCycle;
    @(negedge clk);
    #1;
  endtask

  // Run-level reference: the run ends on the first cycle pc is out of ROM,
  // unless the cycle limit is reached first; a tie counts as a clean end.
  function automatic void modelRun(input int pe, output int cyc, output bit to);
    if (pe >= 0 && pe <= MAX_CYCLES - 1) begin
      cyc = pe + 1;
      to  = 1'b0;
    end else begin
      cyc = MAX_CYCLES;
      to  = 1'b1;
    end
  endfunction

  task automatic fillRandomLoad(input int n);
    loadWord_t w;
    loadQ.delete();
    for (int i = 0; i < n; i++) begin
      w.sel  = 1'($urandom_range(0, 1));
      w.addr = w.sel ? 16'($urandom_range(0, RAM_SIZE + 1)) : 16'($urandom_range(0, ROM_SIZE + 1));
      w.data = 16'($urandom);
      loadQ.push_back(w);
    end
  endtask

  // Pulse start from IDLE/DONE and stream loadQ with random bubbles.
  task automatic loadWords(output int expRomW, output int expRamW);
    bit romHit;
    bit ramHit;
    expRomW = 0;
    expRamW = 0;
    bus.start = 1'b1;
    nextCycle();
    bus.start = 1'b0;
    #1;
    checkOutput("load_entry_ready", 32'(bus.load_ready), 32'd1);
    checkOutput("load_entry_busy", 32'(bus.busy), 32'd1);
    checkOutput("load_entry_cycle_count", bus.cycle_count, 32'd0);
    checkOutput("load_entry_flags", {30'd0, bus.timeout, bus.done}, 32'd0);
    for (int i = 0; i < loadQ.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.load_valid = 1'b0;
        #1;
        checkOutput("load_gap_we", {30'd0, bus.rom_we, bus.ram_we}, 32'd0);
        nextCycle();
      end
      bus.load_valid = 1'b1;
      bus.load_sel   = loadQ[i].sel;
      bus.load_addr  = loadQ[i].addr;
      bus.load_data  = loadQ[i].data;
      bus.load_last  = (i == loadQ.size() - 1);
      #1;
      romHit = !loadQ[i].sel && (int'(loadQ[i].addr) < ROM_SIZE);
      ramHit =  loadQ[i].sel && (int'(loadQ[i].addr) < RAM_SIZE);
      checkOutput("load_ready", 32'(bus.load_ready), 32'd1);
      checkOutput("load_strobes", {30'd0, bus.rom_we, bus.ram_we}, {30'd0, romHit, ramHit});
      checkOutput("load_mem_port", {bus.mem_addr, bus.mem_wdata}, {loadQ[i].addr, loadQ[i].data});
      checkOutput("load_cpu_ctrl", {30'd0, bus.cpu_reset, bus.mem_own}, 32'd3);
      if (romHit) expRomW++;
      if (ramHit) begin
        expRamW++;
        expRam[loadQ[i].addr[1:0]] = loadQ[i].data;
      end
      nextCycle();
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  // One complete run: load loadQ, then check HOLD length, RUN length, the
  // full RAM dump under the chosen dump_ready pattern and the final status.
  task automatic applyStimulus(input int pe, input int expCycles, input bit expTimeout, input int stall);
    int romW0, ramW0, expRomW, expRamW, n, k;
    bit toggle;
    pcEnd = pe;
    romW0 = romWrites;
    ramW0 = ramWrites;
    loadWords(expRomW, expRamW);
    checkOutput("rom_write_count", 32'(romWrites - romW0), 32'(expRomW));
    checkOutput("ram_write_count", 32'(ramWrites - ramW0), 32'(expRamW));

    n = 0;
    while (bus.cpu_reset && !bus.mem_own && n < 50) begin
      n++;
      nextCycle();
    end
    checkOutput("hold_cycles", 32'(n), 32'(RESET_CYCLES));

    n = 0;
    while (!bus.cpu_reset && n < 200) begin
      bus.start = 1'($urandom_range(0, 1));
      #1;
      checkOutput("run_port_released", {29'd0, bus.rom_we, bus.ram_we, bus.mem_own}, 32'd0);
      n++;
      nextCycle();
    end
    checkOutput("run_cycles", 32'(n), 32'(expCycles));

    k = 0;
    n = 0;
    toggle = 1'b1;
    while (k < RAM_SIZE && n < 200) begin
      case (stall)
        0:       bus.dump_ready = 1'b1;
        1:       bus.dump_ready = toggle;
        default: bus.dump_ready = 1'($urandom_range(0, 1));
      endcase
      toggle = ~toggle;
      bus.start = 1'($urandom_range(0, 1));
      #1;
      checkOutput("dump_valid", 32'(bus.dump_valid), 32'd1);
      checkOutput("dump_addr", 32'(bus.dump_addr), 32'(k));
      checkOutput("dump_data", 32'(bus.dump_data), 32'(expRam[k]));
      checkOutput("dump_last", 32'(bus.dump_last), 32'(k == RAM_SIZE - 1));
      checkOutput("dump_port", {bus.mem_addr, 14'd0, bus.cpu_reset, bus.mem_own}, {16'(k), 16'd3});
      if (bus.dump_ready) k++;
      n++;
      nextCycle();
    end
    bus.dump_ready = 1'b0;
    bus.start = 1'b0;
    checkOutput("dump_words", 32'(k), 32'(RAM_SIZE));
    checkOutput("done_flags", {29'd0, bus.done, bus.busy, bus.dump_valid}, 32'd4);
    checkOutput("done_timeout", 32'(bus.timeout), 32'(expTimeout));
    checkOutput("done_cycle_count", bus.cycle_count, 32'(expCycles));
  endtask

  initial begin
    runVec_t table_[6];
    int cyc;
    bit to;
    int n;

    table_[0] = '{3, 15, 16, 1'b0, 2};
    table_[1] = '{2, 14, 15, 1'b0, 1};
    table_[2] = '{4, 16, 16, 1'b1, 2};
    table_[3] = '{1, -1, 16, 1'b1, 1};
    table_[4] = '{2,  0,  1, 1'b0, 2};
    table_[5] = '{5,  7,  8, 1'b0, 0};

    bus.start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_sel = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.load_last = 1'b0;
    bus.dump_ready = 1'b0;

    #2;
    checkOutput("reset_status", {28'd0, bus.busy, bus.done, bus.timeout, bus.load_ready}, 32'd0);
    checkOutput("reset_cpu_ctrl", {30'd0, bus.cpu_reset, bus.mem_own}, 32'd3);
    checkOutput("reset_strobes", {29'd0, bus.rom_we, bus.ram_we, bus.dump_valid}, 32'd0);
    checkOutput("reset_cycle_count", bus.cycle_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Three ROM words then RAM[0]=5 as last word; pc leaves ROM on RUN cycle 3.
    $display("[TB] basic load/run/dump");
    loadQ.delete();
    loadQ.push_back('{1'b0, 16'd0, 16'h1111});
    loadQ.push_back('{1'b0, 16'd1, 16'h2222});
    loadQ.push_back('{1'b0, 16'd2, 16'h3333});
    loadQ.push_back('{1'b1, 16'd0, 16'd5});
    applyStimulus(3, 4, 1'b0, 0);

    // Out-of-range words are accepted without a write.
    $display("[TB] out-of-range load words");
    loadQ.delete();
    loadQ.push_back('{1'b1, 16'(RAM_SIZE), 16'hBEEF});
    loadQ.push_back('{1'b0, 16'(ROM_SIZE), 16'hCAFE});
    loadQ.push_back('{1'b1, 16'd1, 16'h0022});
    applyStimulus(1, 2, 1'b0, 2);

    // pc never leaves the ROM: forced stop at the cycle limit.
    $display("[TB] timeout run");
    loadQ.delete();
    loadQ.push_back('{1'b0, 16'd5, 16'h0055});
    applyStimulus(-1, MAX_CYCLES, 1'b1, 0);

    // Back-to-back run from DONE with a single last word clears the stats.
    $display("[TB] rerun from DONE");
    loadQ.delete();
    loadQ.push_back('{1'b1, 16'd2, 16'h0033});
    applyStimulus(0, 1, 1'b0, 0);

    // Dump of {7,8,9,10} with dump_ready toggling.
    $display("[TB] dump with stalls");
    loadQ.delete();
    for (int i = 0; i < RAM_SIZE; i++) loadQ.push_back('{1'b1, 16'(i), 16'(7 + i)});
    applyStimulus(2, 3, 1'b0, 1);

    $display("[TB] table runs");
    for (int i = 0; i < 6; i++) begin
      fillRandomLoad(table_[i].nWords);
      applyStimulus(table_[i].pcEnd, table_[i].expCycles, table_[i].expTimeout, table_[i].stall);
    end

    $display("[TB] random runs");
    for (int i = 0; i < 8; i++) begin
      int pe;
      pe = $urandom_range(0, 22) - 2;
      modelRun(pe, cyc, to);
      fillRandomLoad($urandom_range(1, 6));
      applyStimulus(pe, cyc, to, 2);
    end

    // Asynchronous reset ten cycles into RUN.
    $display("[TB] reset mid-run");
    loadQ.delete();
    loadQ.push_back('{1'b0, 16'd1, 16'h0077});
    pcEnd = -1;
    loadWords(cyc, n);
    n = 0;
    while (bus.cpu_reset && n < 20) begin
      n++;
      nextCycle();
    end
    checkOutput("midrun_reached_run", 32'(bus.cpu_reset), 32'd0);
    repeat (10) nextCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_status", {28'd0, bus.busy, bus.done, bus.timeout, bus.load_ready}, 32'd0);
    checkOutput("midrun_reset_cpu_ctrl", {30'd0, bus.cpu_reset, bus.mem_own}, 32'd3);
    checkOutput("midrun_reset_strobes", {29'd0, bus.rom_we, bus.ram_we, bus.dump_valid}, 32'd0);
    checkOutput("midrun_reset_cycle_count", bus.cycle_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nextCycle();
    checkOutput("after_reset_idle", {30'd0, bus.busy, bus.done}, 32'd0);

    // Recovery run after the reset.
    modelRun(5, cyc, to);
    fillRandomLoad(3);
    applyStimulus(5, cyc, to, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
